// File: rtl/id_queue_if.sv
// id_queue_if -- fetch-side and execute-side handshake bundle for id_queue.
//
// Parameters:
//   IW  instruction width
//   AW  instruction address width
//
// Signals:
//   in_valid / in_ready      fetch handshake
//   in_instr / in_pc         fetched instruction and its address
//   out_valid / out_ready    execute handshake
//   out_instr / out_pc       issued instruction and its address
//   out_p0, out_p1, out_dst  decoded register addresses
//   out_rd0, out_rd1, out_we port-0 read, port-1 read, register write enables
//   out_bad                  privilege violation flag for the issued instruction
//
// Modports:
//   master  the environment: drives the fetch side and out_ready
//   slave   the queue: accepts fetches, drives the issued instruction
interface id_queue_if #(
    parameter int IW = 16,
    parameter int AW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [AW-1:0] in_pc;

    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [3:0]    out_p0;
    logic [3:0]    out_p1;
    logic [3:0]    out_dst;
    logic          out_rd0;
    logic          out_rd1;
    logic          out_we;
    logic          out_bad;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  out_p0, out_p1, out_dst, out_rd0, out_rd1, out_we, out_bad
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output out_p0, out_p1, out_dst, out_rd0, out_rd1, out_we, out_bad
    );
endinterface

// File: rtl/id_queue.sv
// id_queue -- instruction queue with decode-on-issue output register.
//
// Fetched instructions are held in a circular buffer of DEPTH entries and
// moved in order into a registered issue stage, where the register fields,
// enables and a privilege violation flag are decoded.  A load (opcode 3)
// sitting in the issue register blocks a dependent head for one bubble
// cycle.  flush discards everything held, including a same-cycle push.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   IW     instruction width (decode uses bits [15:0])
//   AW     instruction address width
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    id_queue_if.slave: fetch handshake in, decoded issue out
//   flush  redirect; empties the queue and the issue register
//   mode   privilege mode (2'b01 = user)
//   count  queue occupancy (issue register not included)
//
// Configuration macro:
//   ID_QUEUE_BYPASS_EN  when defined, an instruction arriving at an empty
//                       queue loads the issue register directly (1-cycle
//                       latency) instead of passing through the buffer.
module id_queue #(
    parameter int DEPTH = 4,
    parameter int IW    = 16,
    parameter int AW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    id_queue_if.slave                bus,
    input  logic                     flush,
    input  logic [1:0]               mode,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0] p0;
        logic [3:0] p1;
        logic [3:0] dst;
        logic       rd0;
        logic       rd1;
        logic       we;
        logic       bad;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] ins, input logic [1:0] md);
        dec_t d;
        d = '0;
        case (ins[15:12])
            4'h0, 4'h1, 4'h2: begin
                d.p0  = ins[7:4];
                d.p1  = ins[3:0];
                d.dst = ins[11:8];
                d.rd0 = 1'b1;
                d.rd1 = 1'b1;
                d.we  = (ins[11:8] != 4'h0);
            end
            4'h3: begin
                d.p0  = ins[7:4];
                d.dst = ins[11:8];
                d.rd0 = 1'b1;
                d.we  = (ins[11:8] != 4'h0);
            end
            4'h4: begin
                d.p0  = ins[7:4];
                d.p1  = ins[11:8];
                d.rd0 = 1'b1;
                d.rd1 = 1'b1;
            end
            4'h5, 4'h6, 4'h7: begin
                d.p0  = ins[11:8];
                d.dst = ins[11:8];
                d.rd0 = 1'b1;
                d.we  = (ins[11:8] != 4'h0);
            end
            4'h9: begin
                d.dst = 4'hC;
                d.we  = 1'b1;
            end
            4'hA: begin
                d.p0  = ins[11:8];
                d.rd0 = 1'b1;
            end
            4'hC: begin
                d.p1  = ins[11:8];
                d.rd1 = !ins[1];
            end
            4'hE: begin
                d.dst = ins[11:8];
                d.we  = (ins[11:8] != 4'h0);
            end
            default: ;
        endcase
        // Only addresses actually read or written count toward the user-mode check.
        d.bad = ((md == 2'b01) &&
                 ((d.rd0 && (d.p0  > 4'hC)) ||
                  (d.rd1 && (d.p1  > 4'hC)) ||
                  (d.we  && (d.dst > 4'hC)))) ||
                ((ins[15:12] == 4'hE) && !md[1]);
        return d;
    endfunction

    logic [IW-1:0] mem_instr [DEPTH];
    logic [AW-1:0] mem_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic          slot_free;
    logic          have_head;
    logic [IW-1:0] cand_instr;
    logic [AW-1:0] cand_pc;
    dec_t          cand_dec;
    logic          hazard;
    logic          issue;
    logic          take_bypass;
    logic          push;

    assign bus.in_ready = (count < CW'(DEPTH));

    // The candidate is the queue head, or the incoming instruction when the
    // queue is empty (only used if bypass is compiled in).
    always_comb begin
        slot_free  = !bus.out_valid || bus.out_ready;
        have_head  = (count != '0);
        cand_instr = have_head ? mem_instr[rd_ptr] : bus.in_instr;
        cand_pc    = have_head ? mem_pc[rd_ptr]    : bus.in_pc;
        cand_dec   = decode(cand_instr[15:0], mode);
        hazard     = bus.out_valid && (bus.out_instr[15:12] == 4'h3) &&
                     (bus.out_dst != 4'h0) &&
                     ((cand_dec.rd0 && (cand_dec.p0 == bus.out_dst)) ||
                      (cand_dec.rd1 && (cand_dec.p1 == bus.out_dst)));
        issue      = have_head && slot_free && !hazard && !flush;
`ifdef ID_QUEUE_BYPASS_EN
        take_bypass = !have_head && slot_free && bus.in_valid && !hazard && !flush;
`else
        take_bypass = 1'b0;
`endif
        push       = bus.in_valid && bus.in_ready && !take_bypass && !flush;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.in_instr;
            mem_pc[wr_ptr]    <= bus.in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(issue);
        end
    end

    // Issue register: the bubble after an accepted load falls out naturally,
    // since the load leaves (out_valid drops) while the hazard still blocks
    // the head, and the next cycle sees no load in the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_pc    <= '0;
            bus.out_p0    <= '0;
            bus.out_p1    <= '0;
            bus.out_dst   <= '0;
            bus.out_rd0   <= 1'b0;
            bus.out_rd1   <= 1'b0;
            bus.out_we    <= 1'b0;
            bus.out_bad   <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (issue || take_bypass) begin
            bus.out_valid <= 1'b1;
            bus.out_instr <= cand_instr;
            bus.out_pc    <= cand_pc;
            bus.out_p0    <= cand_dec.p0;
            bus.out_p1    <= cand_dec.p1;
            bus.out_dst   <= cand_dec.dst;
            bus.out_rd0   <= cand_dec.rd0;
            bus.out_rd1   <= cand_dec.rd1;
            bus.out_we    <= cand_dec.we;
            bus.out_bad   <= cand_dec.bad;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
